// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster timing generator.
// Defaults describe 640x480@60 (800x525 total at a 25 MHz pixel rate).
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter plus decode of its next-state value,
// so the parent can register decoded outputs in step with the count.
module timing_axis_counter #(
   parameter int unsigned Width     = 16,
   parameter int unsigned Length    = 800,
   parameter int unsigned Active    = 640,
   parameter int unsigned SyncStart = 656,
   parameter int unsigned SyncLen   = 96
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [Width-1:0] count_o,
   output logic [Width-1:0] count_nxt_o,
   output logic             wrap_o,
   output logic             active_nxt_o,
   output logic             sync_nxt_o
);

   localparam logic [Width-1:0] Last      = Width'(Length - 1);
   localparam logic [Width-1:0] ActEnd    = Width'(Active);
   localparam logic [Width-1:0] SyncFirst = Width'(SyncStart);
   localparam logic [Width-1:0] SyncLast  = Width'(SyncStart + SyncLen - 1);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      wrap_o  = en_i && (count_q == Last);
      count_d = count_q;
      if (en_i) begin
         count_d = wrap_o ? '0 : count_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign count_nxt_o  = count_d;
   assign active_nxt_o = (count_d < ActEnd);
   assign sync_nxt_o   = (count_d >= SyncFirst) && (count_d <= SyncLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with registered sync, active-area
// and strobe outputs aligned to the counts in the same cycle.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        HS_POL   = POL_LOW,
   parameter logic        VS_POL   = POL_LOW,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned FRAME_W  = 16
) (
   input  logic               vga_clk,
   input  logic               vga_rst_n,
   input  logic               pix_en,
   output logic [CNT_W-1:0]   h_count,
   output logic [CNT_W-1:0]   v_count,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [CNT_W-1:0]   x,
   output logic [CNT_W-1:0]   y,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (longint'(H_TOTAL) >= (longint'(1) << CNT_W)) begin : g_h_total_too_wide
      $error("H_TOTAL does not fit in CNT_W bits");
   end
   if (longint'(V_TOTAL) >= (longint'(1) << CNT_W)) begin : g_v_total_too_wide
      $error("V_TOTAL does not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             h_wrap, v_wrap;
   logic             h_act_nxt, v_act_nxt;
   logic             h_sync_nxt, v_sync_nxt;

   timing_axis_counter #(
      .Width     (CNT_W),
      .Length    (H_TOTAL),
      .Active    (H_ACTIVE),
      .SyncStart (H_ACTIVE + H_FP),
      .SyncLen   (H_SYNC)
   ) u_h_axis (
      .clk_i        (vga_clk),
      .rst_ni       (vga_rst_n),
      .en_i         (pix_en),
      .count_o      (h_count),
      .count_nxt_o  (h_nxt),
      .wrap_o       (h_wrap),
      .active_nxt_o (h_act_nxt),
      .sync_nxt_o   (h_sync_nxt)
   );

   timing_axis_counter #(
      .Width     (CNT_W),
      .Length    (V_TOTAL),
      .Active    (V_ACTIVE),
      .SyncStart (V_ACTIVE + V_FP),
      .SyncLen   (V_SYNC)
   ) u_v_axis (
      .clk_i        (vga_clk),
      .rst_ni       (vga_rst_n),
      .en_i         (h_wrap),
      .count_o      (v_count),
      .count_nxt_o  (v_nxt),
      .wrap_o       (v_wrap),
      .active_nxt_o (v_act_nxt),
      .sync_nxt_o   (v_sync_nxt)
   );

   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;

   // Decode is gated by pix_en so the reset-entry state (video_on=0 at 0,0) holds until the
   // first real tick.
   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
      frame_count_d = frame_count_q + FRAME_W'(v_wrap);
      if (pix_en) begin
         hsync_d    = h_sync_nxt ? HS_POL : ~HS_POL;
         vsync_d    = v_sync_nxt ? VS_POL : ~VS_POL;
         video_on_d = h_act_nxt && v_act_nxt;
         x_d        = video_on_d ? h_nxt : '0;
         y_d        = video_on_d ? v_nxt : '0;
      end
   end

   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         video_on_q    <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule
